xgmii_frame_gen: RTL
====================

# xgmii_frame_gen

Parametrised, synthesizable XGMII frame generator for the RX MAC bench and on-board loopback. It produces complete Ethernet frames on a DATA_W/8-lane XGMII bus with correct preamble/SFD, header, incrementing payload, CRC-32 FCS and terminate, followed by a configurable inter-frame gap. Error-injection modes exercise the control decoder, FCS checker and length/type checker. It sits upstream of the RX MAC and drives its rx_d/rx_c inputs.

## Interface
- DATA_W, 64, XGMII data width; 64 or 32 only (LANES = DATA_W/8)
- MAX_LEN, 1518, largest accepted FRAME_LEN in bytes (≤ 16383)
- IFG_WORDS, 1, idle words after the terminate word (≥ 1)

- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  request one frame; sampled only when BUSY=0
- FRAME_LEN  in  14  bytes from DA through FCS inclusive
- DA  in  48  destination address, DA[47:40] sent first
- SA  in  48  source address, SA[47:40] sent first
- LEN_TYPE  in  16  LEN_TYPE[15:8] sent first
- ERR_MODE  in  2  bit0 invert FCS; bit1 insert /E/ in lane 0 of third data word
- TXD  out  DATA_W  XGMII data, lane 0 = [7:0]
- TXC  out  LANES  XGMII control, 1 = control character
- BUSY  out  1  frame or IFG in progress
- DONE  out  1  one-cycle pulse with the terminate word
- REJECT  out  1  one-cycle pulse when START carries FRAME_LEN < 18 or > MAX_LEN
- FRAMES_SENT  out  32  count of completed frames, wraps

## Operation
- States: IDLE, PRE, DATA, TERM, IFG.
- IDLE: TXD all lanes 0x07, TXC all ones. START with legal length latches FRAME_LEN, DA, SA, LEN_TYPE, ERR_MODE → PRE. Illegal length → REJECT, stay IDLE.
- PRE: lane 0 = 0xFB (ctrl), then six 0x55, 0xD5 (data). DATA_W=64: one word, TXC=0x01. DATA_W=32: two words, TXC=0x1 then 0x0.
- DATA: byte index i from 0: 0–5 DA, 6–11 SA, 12–13 LEN_TYPE, 14..FRAME_LEN-5 payload = (i-14)[7:0], last 4 FCS (CRC-32 of bytes 0..FRAME_LEN-5, reflected, complemented, LSB byte first), XOR 0xFFFFFFFF if ERR_MODE[0].
- Final data word: lane (FRAME_LEN mod LANES) = 0xFD ctrl, higher lanes 0x07 ctrl, DONE=1, FRAMES_SENT++ → IFG. If FRAME_LEN mod LANES = 0, extra TERM word: lane 0 = 0xFD, rest 0x07, TXC all ones.
- ERR_MODE[1]: lane 0 of third data word replaced by 0xFE with its TXC bit set; byte count and CRC unaffected.
- IFG: IFG_WORDS idle words, then IDLE. START during BUSY ignored, no REJECT.
- CRC: running 32-bit register, init 0xFFFFFFFF at PRE. When FCS starts mid-word, FCS lanes use combinational next-CRC over that word's preceding valid lanes; FCS bytes spilling into the next word come from the stored final CRC.
- RESET at any time: next cycle idle words, state IDLE, BUSY/DONE/REJECT 0, FRAMES_SENT 0; no terminate emitted for an aborted frame.

## Timing
- All outputs registered. START at edge N → preamble word visible after edge N+1, BUSY=1 from the same cycle.
- Words per frame (64-bit): 1 + ceil(FRAME_LEN/8) + (FRAME_LEN mod 8 = 0 ? 1 : 0), then IFG_WORDS.
- Earliest next START accepted in cycle after BUSY falls; back-to-back START held high yields frames separated by exactly IFG_WORDS idle words.
- REJECT asserted one cycle after illegal START.
- Reset values: TXD = repeated 0x07, TXC all ones, BUSY 0, DONE 0, REJECT 0, FRAMES_SENT 0.

## Structure
- Package xgmii_pkg: constants IDLE 0x07, START 0xFB, TERM 0xFD, ERROR 0xFE, PRE 0x55, SFD 0xD5, CRC_POLY 0x04C11DB7, CRC_RESIDUE 0xC704DD7B, MIN_LEN 18; state enum.
- Sub-module crc32_lanes: combinational next-CRC over LANES bytes with per-lane valid mask, parameter LANES.

## Test plan
- DATA_W=64, FRAME_LEN=64, DA=FF..FF, ERR_MODE=0 → 10 frame words, TERM word TXC=0xFF, CRC over bytes incl. FCS gives residue 0xC704DD7B, DONE one pulse.
- FRAME_LEN=67 → final data word TXC=0xF8, 0xFD in lane 3, no extra TERM word.
- ERR_MODE=01 → FCS bits inverted, residue ≠ 0xC704DD7B; ERR_MODE=10 → third data word TXD[7:0]=0xFE, TXC[0]=1.
- START held high, IFG_WORDS=3 → exactly 3 idle words between frames, FRAMES_SENT increments by 1 per frame.
- FRAME_LEN=17 and MAX_LEN+1 → REJECT pulse, TX stays idle, BUSY 0.
- DATA_W=32, FRAME_LEN=64; RESET asserted in 5th data word → preamble 2 words TXC 0x1/0x0, idle on cycle after reset, FRAMES_SENT 0.

Source files
------------

// File: rtl/xgmii_pkg.sv
// xgmii_pkg: shared constants, state encoding and the byte-wise CRC-32 step for
// the XGMII frame generator.
//   - XGMII control characters (idle, start, terminate, error) and preamble/SFD bytes
//   - Ethernet CRC-32 polynomial (normal and reflected form) and good-frame residue
//   - frame generator state enum
package xgmii_pkg;

   localparam logic [7:0] XG_IDLE  = 8'h07;
   localparam logic [7:0] XG_START = 8'hFB;
   localparam logic [7:0] XG_TERM  = 8'hFD;
   localparam logic [7:0] XG_ERROR = 8'hFE;
   localparam logic [7:0] XG_PRE   = 8'h55;
   localparam logic [7:0] XG_SFD   = 8'hD5;

   localparam int MIN_LEN = 18;

   function automatic logic [31:0] bitrev32(input logic [31:0] x);
      logic [31:0] r;
      for (int k = 0; k < 32; k++) r[k] = x[31-k];
      return r;
   endfunction

   localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
   // Ethernet sends bytes LSB first, so the register runs in reflected form.
   localparam logic [31:0] CRC_POLY_REFL = bitrev32(CRC_POLY);
   localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_TERM, S_IFG} state_e;

   // One byte through the reflected CRC-32 register.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
      return c;
   endfunction

endpackage

// File: rtl/xgmii_frame_gen_crc32_lanes.sv
// crc32_lanes: combinational next-CRC over one bus word.
//   crc_i  running reflected CRC register
//   data_i LANES bytes, lane 0 = [7:0], processed lane 0 first
//   vld_i  per-lane valid mask; invalid lanes leave the CRC untouched
//   crc_o  CRC after all valid lanes
module crc32_lanes
   import xgmii_pkg::*;
#(
   parameter int LANES = 8
) (
   input  logic [31:0]        crc_i,
   input  logic [LANES*8-1:0] data_i,
   input  logic [LANES-1:0]   vld_i,
   output logic [31:0]        crc_o
);

   always_comb begin
      crc_o = crc_i;
      for (int l = 0; l < LANES; l++)
         if (vld_i[l]) crc_o = crc32_byte(crc_o, data_i[l*8 +: 8]);
   end

endmodule

// File: rtl/xgmii_frame_gen.sv
// xgmii_frame_gen: emits one complete Ethernet frame per accepted start request on
// an XGMII bus: start/preamble/SFD, DA, SA, length/type, incrementing payload,
// CRC-32 FCS, terminate, then IFG_WORDS idle words. Error injection can invert the
// FCS or put /E/ in lane 0 of the third data word.
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             frame request, honoured only while idle
//   frame_len_i         bytes DA..FCS inclusive, legal range MIN_LEN..MAX_LEN
//   da_i, sa_i          addresses, MSB byte first on the wire
//   len_type_i          length/type, MSB byte first
//   err_mode_i          bit0 invert FCS, bit1 /E/ in third data word
//   txd_o, txc_o        XGMII data / control, lane 0 = [7:0]
//   busy_o              frame or gap in progress
//   done_o              pulse with the word carrying the terminate
//   reject_o            pulse after a start with an illegal length
//   frames_sent_o       wrapping count of completed frames
module xgmii_frame_gen
   import xgmii_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int MAX_LEN   = 1518,
   parameter int IFG_WORDS = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [13:0]         frame_len_i,
   input  logic [47:0]         da_i,
   input  logic [47:0]         sa_i,
   input  logic [15:0]         len_type_i,
   input  logic [1:0]          err_mode_i,
   output logic [DATA_W-1:0]   txd_o,
   output logic [DATA_W/8-1:0] txc_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                reject_o,
   output logic [31:0]         frames_sent_o
);

   localparam int LANES = DATA_W / 8;
   localparam int IFG_W = (IFG_WORDS > 2) ? $clog2(IFG_WORDS) : 1;
   localparam logic [15:0] LANES16 = 16'(LANES);

   state_e            state_q, state_d;
   logic [15:0]       idx_q, idx_d;          // byte index of lane 0 (preamble or frame)
   logic [IFG_W-1:0]  ifg_q, ifg_d;
   logic [31:0]       crc_q, crc_d, crc_nxt, fcs;
   logic [31:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0] txd_q, txd_d;
   logic [LANES-1:0]  txc_q, txc_d;
   logic              done_q, done_d, rej_q, rej_d, busy_q;

   logic [13:0]       len_q;
   logic [47:0]       da_q, sa_q;
   logic [15:0]       lt_q;
   logic [1:0]        err_q;

   logic [7:0]        hdr [16];
   logic [15:0]       bidx [LANES];
   logic [1:0]        fidx [LANES];
   logic [DATA_W-1:0] lane_dat;
   logic [LANES-1:0]  lane_vld;
   logic [15:0]       len16, dlen16;
   logic              legal, accept;

   assign len16  = {2'b00, len_q};
   assign dlen16 = len16 - 16'd4;          // first FCS byte index
   assign legal  = (frame_len_i >= 14'(MIN_LEN)) && (frame_len_i <= 14'(MAX_LEN));
   assign accept = (state_q == S_IDLE) && start_i && legal;

   always_comb begin
      for (int b = 0; b < 6; b++) begin
         hdr[b]   = da_q[47-8*b -: 8];
         hdr[b+6] = sa_q[47-8*b -: 8];
      end
      hdr[12] = lt_q[15:8];
      hdr[13] = lt_q[7:0];
      hdr[14] = 8'h00;
      hdr[15] = 8'h00;
   end

   // Per-lane frame byte and whether it feeds the CRC (header or payload).
   always_comb begin
      lane_dat = '0;
      lane_vld = '0;
      for (int l = 0; l < LANES; l++) begin
         bidx[l] = idx_q + 16'(l);
         fidx[l] = 2'(bidx[l] - dlen16);
         if (bidx[l] < 16'd14) lane_dat[l*8 +: 8] = hdr[bidx[l][3:0]];
         else                  lane_dat[l*8 +: 8] = 8'(bidx[l] - 16'd14);
         lane_vld[l] = (state_q == S_DATA) && (bidx[l] < dlen16);
      end
   end

   crc32_lanes #(.LANES(LANES)) u_crc (
      .crc_i  (crc_q),
      .data_i (lane_dat),
      .vld_i  (lane_vld),
      .crc_o  (crc_nxt)
   );

   // FCS lanes always read the CRC including this word's data lanes; once the
   // data is exhausted the mask is empty and crc_nxt equals the stored final CRC.
   assign fcs = ~crc_nxt ^ {32{err_q[0]}};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ifg_d   = ifg_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      txd_d   = {LANES{XG_IDLE}};
      txc_d   = '1;
      done_d  = 1'b0;
      rej_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (legal) begin
                  state_d = S_PRE;
                  idx_d   = '0;
                  crc_d   = '1;
               end else begin
                  rej_d = 1'b1;
               end
            end
         end
         S_PRE: begin
            txc_d = '0;
            for (int l = 0; l < LANES; l++) begin
               if (bidx[l] == 16'd0) begin
                  txd_d[l*8 +: 8] = XG_START;
                  txc_d[l]        = 1'b1;
               end else if (bidx[l] == 16'd7) begin
                  txd_d[l*8 +: 8] = XG_SFD;
               end else begin
                  txd_d[l*8 +: 8] = XG_PRE;
               end
            end
            idx_d = idx_q + LANES16;
            if (idx_q + LANES16 == 16'd8) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            txc_d = '0;
            for (int l = 0; l < LANES; l++) begin
               if (lane_vld[l]) begin
                  txd_d[l*8 +: 8] = lane_dat[l*8 +: 8];
               end else if (bidx[l] < len16) begin
                  txd_d[l*8 +: 8] = fcs[{fidx[l], 3'b000} +: 8];
               end else if (bidx[l] == len16) begin
                  txd_d[l*8 +: 8] = XG_TERM;
                  txc_d[l]        = 1'b1;
               end else begin
                  txd_d[l*8 +: 8] = XG_IDLE;
                  txc_d[l]        = 1'b1;
               end
            end
            // /E/ replaces the wire byte only; the CRC already consumed the real one.
            if (err_q[1] && (idx_q == 16'(2*LANES))) begin
               txd_d[7:0] = XG_ERROR;
               txc_d[0]   = 1'b1;
            end
            crc_d = crc_nxt;
            idx_d = idx_q + LANES16;
            if (idx_q + LANES16 > len16) begin
               done_d  = 1'b1;
               cnt_d   = cnt_q + 32'd1;
               ifg_d   = '0;
               state_d = (IFG_WORDS > 1) ? S_IFG : S_IDLE;
            end else if (idx_q + LANES16 == len16) begin
               state_d = S_TERM;
            end
         end
         S_TERM: begin
            txd_d[7:0] = XG_TERM;
            done_d     = 1'b1;
            cnt_d      = cnt_q + 32'd1;
            ifg_d      = '0;
            state_d    = (IFG_WORDS > 1) ? S_IFG : S_IDLE;
         end
         S_IFG: begin
            // The IDLE cycle that follows supplies the last gap word, so a start
            // held high lands exactly IFG_WORDS idles after the terminate.
            ifg_d = ifg_q + 1'b1;
            if (ifg_q == IFG_W'(IFG_WORDS - 2)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ifg_q   <= '0;
         crc_q   <= '1;
         cnt_q   <= '0;
         txd_q   <= {LANES{XG_IDLE}};
         txc_q   <= '1;
         done_q  <= 1'b0;
         rej_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ifg_q   <= ifg_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         txd_q   <= txd_d;
         txc_q   <= txc_d;
         done_q  <= done_d;
         rej_q   <= rej_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         len_q <= frame_len_i;
         da_q  <= da_i;
         sa_q  <= sa_i;
         lt_q  <= len_type_i;
         err_q <= err_mode_i;
      end
   end

   assign txd_o         = txd_q;
   assign txc_o         = txc_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign reject_o      = rej_q;
   assign frames_sent_o = cnt_q;

endmodule
